// File: rtl/pipe_stage_s.sv
// Reusable pipeline stage register with valid/ready backpressure, flush and a stall counter.
// Define PIPE_STAGE_SKID_EN to use a 2-entry skid buffer, which removes the out_ready -> in_ready path.
module pipe_stage_s #(
  parameter int unsigned DATA_W     = 96,
  parameter int unsigned CTRL_W     = 16,
  parameter int unsigned CLEAR_DATA = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept, release_beat;
  logic [DATA_W-1:0] flush_data;

  assign accept       = in_valid && in_ready;
  assign release_beat = out_valid_q && out_ready;
  assign flush_data   = (CLEAR_DATA != 0) ? '0 : out_data_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!flush && out_valid_q && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

  // Flush still forces acceptance; out_ready never reaches in_ready here.
  assign in_ready = flush || !skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ctrl_d   = out_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      out_ctrl_d   = '0;
      out_data_d   = flush_data;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (skid_valid_q) begin
      if (release_beat) begin
        out_data_d   = skid_data_q;
        out_ctrl_d   = skid_ctrl_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end
    end else if (!out_valid_q || out_ready) begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_ctrl_d  = in_ctrl;
      end else begin
        out_valid_d = 1'b0;
        out_ctrl_d  = '0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_ctrl_d  = in_ctrl;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end
`else
  assign in_ready = flush || !out_valid_q || out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
      out_data_d  = flush_data;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_ctrl_d  = in_ctrl;
    end else if (release_beat) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ctrl  = out_ctrl_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_s.sv
// Bench for pipe_stage_s: one instance with CLEAR_DATA=0 and one with CLEAR_DATA=1 share stimulus;
// a directed vector table, hand sequences and a random run against a queue-based reference model.
module tb_pipe_stage_s;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NW = 4;
  localparam int unsigned CNT_MAX = (1 << NW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, flush, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [DW-1:0] out_data_a, out_data_b;
  logic [CW-1:0] out_ctrl_a, out_ctrl_b;
  logic [NW-1:0] stall_a, stall_b;

  pipe_stage_s #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(0), .CNT_W(NW)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_ctrl(out_ctrl_a), .stall_cnt(stall_a));

  pipe_stage_s #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1), .CNT_W(NW)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_ctrl(out_ctrl_b), .stall_cnt(stall_b));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of capacity 1 (or 2 with the skid buffer).
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;
  beat_t         q[$];
  logic [DW-1:0] held_a, held_b;
  int unsigned   m_cnt;

  function automatic bit m_in_ready();
`ifdef PIPE_STAGE_SKID_EN
    return flush || (q.size() < 2);
`else
    return flush || (q.size() == 0) || out_ready;
`endif
  endfunction

  task automatic m_reset();
    q.delete();
    held_a = '0;
    held_b = '0;
    m_cnt  = 0;
  endtask

  task automatic m_edge();
    bit ir;
    ir = m_in_ready();
    if (flush) begin
      q.delete();
      held_b = '0;
    end else begin
      if (q.size() > 0 && !out_ready && m_cnt < CNT_MAX) m_cnt++;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && ir) q.push_back('{d: in_data, c: in_ctrl});
    end
    if (q.size() > 0) begin
      held_a = q[0].d;
      held_b = q[0].d;
    end
  endtask

  task automatic check_outs();
    logic          ev;
    logic [CW-1:0] ec;
    ev = (q.size() > 0);
    ec = ev ? q[0].c : '0;
    chk("out_valid_a", 32'(out_valid_a), 32'(ev));
    chk("out_valid_b", 32'(out_valid_b), 32'(ev));
    chk("out_data_a",  32'(out_data_a),  32'(held_a));
    chk("out_data_b",  32'(out_data_b),  32'(held_b));
    chk("out_ctrl_a",  32'(out_ctrl_a),  32'(ec));
    chk("out_ctrl_b",  32'(out_ctrl_b),  32'(ec));
    chk("stall_a",     32'(stall_a),     m_cnt);
    chk("stall_b",     32'(stall_b),     m_cnt);
  endtask

  // Called just after a rising edge; drives, checks in_ready, clocks, checks outputs.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit f, input bit r);
    in_valid = v; in_data = d; in_ctrl = c; flush = f; out_ready = r;
    #1;
    chk("in_ready_a", 32'(in_ready_a), 32'(m_in_ready()));
    chk("in_ready_b", 32'(in_ready_b), 32'(m_in_ready()));
    m_edge();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  typedef struct {
    bit            v;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    bit            f, r;
    bit            e_ir, e_ov;
    logic [DW-1:0] e_da, e_db;
    logic [CW-1:0] e_c;
    int unsigned   e_st;
  } vec_t;
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 32'h1,  16'h1,  0, 1, 1, 1, 32'h1,  32'h1,  16'h1,  0};
    tbl[1]  = '{1, 32'h2,  16'h2,  0, 1, 1, 1, 32'h2,  32'h2,  16'h2,  0};
    tbl[2]  = '{1, 32'h3,  16'h3,  0, 1, 1, 1, 32'h3,  32'h3,  16'h3,  0};
    tbl[3]  = '{1, 32'h11, 16'h11, 0, 1, 1, 1, 32'h11, 32'h11, 16'h11, 0};
    tbl[4]  = '{1, 32'h22, 16'h22, 0, 0, 0, 1, 32'h11, 32'h11, 16'h11, 1};
    tbl[5]  = '{1, 32'h22, 16'h22, 0, 0, 0, 1, 32'h11, 32'h11, 16'h11, 2};
    tbl[6]  = '{1, 32'h22, 16'h22, 0, 0, 0, 1, 32'h11, 32'h11, 16'h11, 3};
    tbl[7]  = '{1, 32'h22, 16'h22, 0, 1, 1, 1, 32'h22, 32'h22, 16'h22, 3};
    tbl[8]  = '{0, 32'h0,  16'h0,  0, 1, 1, 0, 32'h22, 32'h22, 16'h0,  3};
    tbl[9]  = '{1, 32'h44, 16'hFF, 0, 0, 1, 1, 32'h44, 32'h44, 16'hFF, 3};
    tbl[10] = '{1, 32'h33, 16'h33, 1, 0, 1, 0, 32'h44, 32'h0,  16'h0,  3};
    tbl[11] = '{0, 32'h0,  16'h0,  0, 0, 1, 0, 32'h44, 32'h0,  16'h0,  3};

    // Reset with a beat offered: nothing may be captured.
    reset = 1'b0; in_valid = 1'b1; in_data = 32'hABC; in_ctrl = 16'h1;
    flush = 1'b0; out_ready = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid_a), 32'h0);
    chk("rst_out_data",  32'(out_data_a),  32'h0);
    chk("rst_out_ctrl",  32'(out_ctrl_a),  32'h0);
    chk("rst_stall",     32'(stall_a),     32'h0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready",  32'(in_ready_a),  32'h1);
    chk("post_rst_out_valid", 32'(out_valid_a), 32'h0);

`ifndef PIPE_STAGE_SKID_EN
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; in_ctrl = tbl[i].c;
      flush = tbl[i].f; out_ready = tbl[i].r;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready_a), 32'(tbl[i].e_ir));
      m_edge();
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid_a), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_out_data_a", i), 32'(out_data_a), 32'(tbl[i].e_da));
      chk($sformatf("tbl%0d_out_data_b", i), 32'(out_data_b), 32'(tbl[i].e_db));
      chk($sformatf("tbl%0d_out_ctrl", i), 32'(out_ctrl_a), 32'(tbl[i].e_c));
      chk($sformatf("tbl%0d_stall", i), 32'(stall_a), tbl[i].e_st);
    end
`endif

    // Back-to-back streaming of 1..8.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, DW'(i), CW'(i), 1'b0, 1'b1);
      chk("stream_data", 32'(out_data_a), 32'(i));
    end

    // Hold a beat under backpressure long enough to saturate the counter.
    cycle(1'b1, 32'h55, 16'h5, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h66, 16'h6, 1'b0, 1'b0);
    chk("stall_sat",      32'(stall_a),    CNT_MAX);
    chk("stall_sat_data", 32'(out_data_a), 32'h55);

    // Asynchronous reset between edges while stalled.
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid_a), 32'h0);
    chk("mid_rst_stall",     32'(stall_a),     32'h0);
    chk("mid_rst_out_ctrl",  32'(out_ctrl_b),  32'h0);
    chk("mid_rst_out_data",  32'(out_data_a),  32'h0);
    m_reset();
    #2 reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready",   32'(in_ready_a),  32'h1);
    chk("mid_rst_valid_after", 32'(out_valid_a), 32'h0);

    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), DW'($urandom), CW'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
